// File: rtl/fp_compare_pipe.sv
// Pipelined FloPoCo float comparator: LT/LE/EQ/GE/GT/NE/MIN/MAX.
// Ports: in_* operands/op/tag, out_* result, nan_cnt unordered stats.
module fp_compare_pipe #(
  parameter int WE    = 6,
  parameter int WF    = 11,
  parameter int LAT   = 1,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WE+WF+2:0]     in_a,
  input  logic [WE+WF+2:0]     in_b,
  input  logic [2:0]           in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  output logic                 out_flag,
  output logic [WE+WF+2:0]     out_val,
  output logic                 out_unord,
  output logic [TAG_W-1:0]     out_tag,
  output logic [15:0]          nan_cnt,
  input  logic                 cnt_clr
);

  localparam int W  = WE + WF + 3;
  localparam int KW = W - 1;

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [KW-1:0]    ka;
    logic [KW-1:0]    kb;
    logic             sa;
    logic             sb;
    logic             za;
    logic             zb;
    logic             na;
    logic             nb;
  } key_t;

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             lt;
    logic             eq;
    logic             un;
    logic             na;
  } cmp_t;

  // Zero operands collapse to an all-zero key, so +0/-0 and
  // any exp/frac garbage under exc=00 compare equal.
  function automatic logic [KW-1:0] key_of(logic [W-1:0] x);
    logic [KW-1:0] k;
    k = '0;
    if (x[W-1:W-2] != 2'b00) k = {x[W-1:W-2], x[W-4:0]};
    return k;
  endfunction

  key_t key_c, key_s;
  cmp_t cmp_c, cmp_s;

  always_comb begin
    key_c     = '0;
    key_c.vld = in_valid;
    key_c.op  = in_op;
    key_c.tag = in_tag;
    key_c.a   = in_a;
    key_c.b   = in_b;
    key_c.ka  = key_of(in_a);
    key_c.kb  = key_of(in_b);
    key_c.sa  = in_a[W-3];
    key_c.sb  = in_b[W-3];
    key_c.za  = (in_a[W-1:W-2] == 2'b00);
    key_c.zb  = (in_b[W-1:W-2] == 2'b00);
    key_c.na  = (in_a[W-1:W-2] == 2'b11);
    key_c.nb  = (in_b[W-1:W-2] == 2'b11);
  end

  if (LAT >= 2) begin : g_key
    key_t key_d, key_q;
    always_comb begin
      key_d     = key_q;
      key_d.vld = key_c.vld;
      if (key_c.vld) key_d = key_c;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) key_q <= '0;
      else     key_q <= key_d;
    end
    assign key_s = key_q;
  end else begin : g_nokey
    assign key_s = key_c;
  end

  always_comb begin
    logic bz;
    cmp_c     = '0;
    cmp_c.vld = key_s.vld;
    cmp_c.op  = key_s.op;
    cmp_c.tag = key_s.tag;
    cmp_c.a   = key_s.a;
    cmp_c.b   = key_s.b;
    cmp_c.na  = key_s.na;
    cmp_c.un  = key_s.na | key_s.nb;
    bz        = key_s.za & key_s.zb;
    if (!cmp_c.un) begin
      cmp_c.eq = (key_s.ka == key_s.kb) &&
                 ((key_s.sa == key_s.sb) || bz);
      if (bz)                    cmp_c.lt = 1'b0;
      else if (key_s.sa != key_s.sb) cmp_c.lt = key_s.sa;
      else if (!key_s.sa)        cmp_c.lt = key_s.ka < key_s.kb;
      else                       cmp_c.lt = key_s.ka > key_s.kb;
    end
  end

  if (LAT >= 3) begin : g_cmp
    localparam int NC = LAT - 2;
    cmp_t src   [NC];
    cmp_t cmp_d [NC];
    cmp_t cmp_q [NC];
    always_comb begin
      src[0] = cmp_c;
      for (int i = 1; i < NC; i++) src[i] = cmp_q[i-1];
      for (int i = 0; i < NC; i++) begin
        cmp_d[i]     = cmp_q[i];
        cmp_d[i].vld = src[i].vld;
        if (src[i].vld) cmp_d[i] = src[i];
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < NC; i++) cmp_q[i] <= '0;
      end else begin
        for (int i = 0; i < NC; i++) cmp_q[i] <= cmp_d[i];
      end
    end
    assign cmp_s = cmp_q[NC-1];
  end else begin : g_nocmp
    assign cmp_s = cmp_c;
  end

  logic         res_flag;
  logic [W-1:0] res_val;
  logic [W-1:0] unord_pick;

  // Unordered MIN/MAX propagate a NaN, preferring operand A.
  assign unord_pick = cmp_s.na ? cmp_s.a : cmp_s.b;

  always_comb begin
    res_flag = 1'b0;
    res_val  = cmp_s.a;
    unique case (cmp_s.op)
      3'd0: res_flag = cmp_s.lt;
      3'd1: res_flag = cmp_s.lt | cmp_s.eq;
      3'd2: res_flag = cmp_s.eq;
      3'd3: res_flag = !cmp_s.un & !cmp_s.lt;
      3'd4: res_flag = !cmp_s.un & !cmp_s.lt & !cmp_s.eq;
      3'd5: res_flag = !cmp_s.eq;
      3'd6: res_val  = cmp_s.un ? unord_pick :
                       (!cmp_s.lt && !cmp_s.eq) ? cmp_s.b : cmp_s.a;
      3'd7: res_val  = cmp_s.un ? unord_pick :
                       cmp_s.lt ? cmp_s.b : cmp_s.a;
      default: res_flag = 1'b0;
    endcase
  end

  logic             out_valid_d, out_valid_q;
  logic             out_flag_d, out_flag_q;
  logic [W-1:0]     out_val_d, out_val_q;
  logic             out_unord_d, out_unord_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic [15:0]      nan_cnt_d, nan_cnt_q;
  logic             in_unord;

  always_comb begin
    out_valid_d = cmp_s.vld;
    out_flag_d  = out_flag_q;
    out_val_d   = out_val_q;
    out_unord_d = out_unord_q;
    out_tag_d   = out_tag_q;
    if (cmp_s.vld) begin
      out_flag_d  = res_flag;
      out_val_d   = res_val;
      out_unord_d = cmp_s.un;
      out_tag_d   = cmp_s.tag;
    end
  end

  assign in_unord = (in_a[W-1:W-2] == 2'b11) |
                    (in_b[W-1:W-2] == 2'b11);

  always_comb begin
    nan_cnt_d = nan_cnt_q;
    if (cnt_clr)
      nan_cnt_d = '0;
    else if (in_valid && in_unord && nan_cnt_q != 16'hFFFF)
      nan_cnt_d = nan_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_flag_q  <= 1'b0;
      out_val_q   <= '0;
      out_unord_q <= 1'b0;
      out_tag_q   <= '0;
      nan_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
      out_val_q   <= out_val_d;
      out_unord_q <= out_unord_d;
      out_tag_q   <= out_tag_d;
      nan_cnt_q   <= nan_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;
  assign out_val   = out_val_q;
  assign out_unord = out_unord_q;
  assign out_tag   = out_tag_q;
  assign nan_cnt   = nan_cnt_q;

endmodule
